// File: rtl/led_pio_blink_if.sv
// Avalon-MM slave bus bundle for the LED PIO with hardware blink.
//   address    : word address of register (3 bits)
//   chipselect : slave select
//   write_n    : write strobe, active-low
//   writedata  : write data (32 bits)
//   readdata   : read data, combinational from address (32 bits)
interface led_pio_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pio_blink.sv
// Parametrised Avalon-MM LED output port with atomic set/clear/toggle and
// per-bit hardware blink. Zero read latency, no wait states.
//   clk      : system clock
//   reset_n  : asynchronous reset, active-low
//   bus      : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port : LED drive, data masked by the blink phase
// Register map: 0 DATA, 1 BMASK, 2 BPERIOD, 3 STATUS, 4 OUTSET, 5 OUTCLR,
// 6 OUTTGL, 7 unused.
module led_pio_blink #(
  parameter int unsigned              DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0]    RESET_VALUE  = '0,
  parameter int unsigned              CNT_WIDTH    = 24,
  parameter logic [CNT_WIDTH-1:0]     RESET_PERIOD = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  led_pio_blink_if.slave        bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_BMASK   = 3'd1;
  localparam logic [2:0] ADDR_BPERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_OUTTGL  = 3'd6;

  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] bmask;
  logic [CNT_WIDTH-1:0]  bperiod;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  phase;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [CNT_WIDTH-1:0]  wd_cnt;
  logic                  bperiod_wr;
  logic                  terminal;

  // Truncating casts drop writedata bits above each register's width.
  assign wr         = bus.chipselect & ~bus.write_n;
  assign wd_data    = DATA_WIDTH'(bus.writedata);
  assign wd_cnt     = CNT_WIDTH'(bus.writedata);
  assign bperiod_wr = wr && (bus.address == ADDR_BPERIOD);
  assign terminal   = (cnt == (bperiod - CNT_WIDTH'(1)));

  // DATA register including the atomic set/clear/toggle aliases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:   data <= wd_data;
        ADDR_OUTSET: data <= data | wd_data;
        ADDR_OUTCLR: data <= data & ~wd_data;
        ADDR_OUTTGL: data <= data ^ wd_data;
        default:     data <= data;
      endcase
    end
  end

  // Blink enable mask and half-period register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bmask   <= '0;
      bperiod <= RESET_PERIOD;
    end else if (wr) begin
      if (bus.address == ADDR_BMASK)   bmask   <= wd_data;
      if (bus.address == ADDR_BPERIOD) bperiod <= wd_cnt;
    end
  end

  // Blink timer; a BPERIOD write restarts the half-period in the on phase
  // and takes priority over a coincident terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (bperiod_wr || (bperiod == '0)) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (terminal) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_WIDTH'(1);
    end
  end

  // Zero-latency read mux; STATUS places cnt at bit 8, truncated to 32 bits.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = 32'(data);
      ADDR_BMASK:   bus.readdata = 32'(bmask);
      ADDR_BPERIOD: bus.readdata = 32'(bperiod);
      ADDR_STATUS:  bus.readdata = 32'({cnt, 7'b0, phase});
      default:      bus.readdata = '0;
    endcase
  end

  // Blinking bits are forced off during the off phase.
  assign out_port = data & ~(bmask & {DATA_WIDTH{~phase}});

endmodule

// File: tb/tb_led_pio_blink.sv
// Directed testbench for led_pio_blink (DW=8, RESET_VALUE=A5, CNT_WIDTH=24).
module tb_led_pio_blink;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;

  int checks   = 0;
  int failures = 0;

  led_pio_blink_if bus ();

  led_pio_blink #(
    .DATA_WIDTH   (8),
    .RESET_VALUE  (8'hA5),
    .CNT_WIDTH    (24),
    .RESET_PERIOD (24'd0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle write; returns at the negedge after the write edge.
  task automatic bus_write(input logic cs, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = cs;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    logic [7:0]  exp_out;
    logic [31:0] exp_stat;

    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    // Reset values
    #12;
    check("rst_out", 32'(out_port), 32'hA5);
    read_check("rst_data", 3'd0, 32'hA5);
    read_check("rst_bmask", 3'd1, 32'h0);
    read_check("rst_bperiod", 3'd2, 32'h0);
    read_check("rst_status", 3'd3, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // DATA write with wide writedata, and chipselect gating
    bus_write(1'b1, 3'd0, 32'h1FF);
    check("data_out", 32'(out_port), 32'hFF);
    read_check("data_rd", 3'd0, 32'h000000FF);
    bus_write(1'b0, 3'd0, 32'h0);
    check("nocs_out", 32'(out_port), 32'hFF);
    bus_write(1'b1, 3'd7, 32'h0);
    check("addr7_wr", 32'(out_port), 32'hFF);

    // Atomic set/clear/toggle
    bus_write(1'b1, 3'd0, 32'hF0);
    check("data_f0", 32'(out_port), 32'hF0);
    bus_write(1'b1, 3'd4, 32'h0F);
    check("outset", 32'(out_port), 32'hFF);
    bus_write(1'b1, 3'd5, 32'h81);
    check("outclr", 32'(out_port), 32'h7E);
    bus_write(1'b1, 3'd6, 32'hFF);
    check("outtgl", 32'(out_port), 32'h81);
    bus_write(1'b1, 3'd4, 32'hFFFF_FF00);
    check("outset_hi", 32'(out_port), 32'h81);
    read_check("rd4", 3'd4, 32'h0);
    read_check("rd5", 3'd5, 32'h0);
    read_check("rd6", 3'd6, 32'h0);
    read_check("rd7", 3'd7, 32'h0);

    // Blink with half-period 3 on bit0
    bus_write(1'b1, 3'd0, 32'hFF);
    bus_write(1'b1, 3'd1, 32'h01);
    read_check("bmask_rd", 3'd1, 32'h01);
    bus_write(1'b1, 3'd2, 32'd3);
    read_check("bperiod_rd", 3'd2, 32'd3);
    for (int k = 0; k < 12; k++) begin
      exp_out  = (((k / 3) % 2) == 0) ? 8'hFF : 8'hFE;
      exp_stat = (32'(k % 3) << 8) | ((((k / 3) % 2) == 0) ? 32'h1 : 32'h0);
      check("blink3_out", 32'(out_port), 32'(exp_out));
      read_check("blink3_stat", 3'd3, exp_stat);
      @(negedge clk);
    end

    // Rewrite period during the off phase: restart on, then 5/5
    repeat (3) @(negedge clk);
    check("off_phase", 32'(out_port), 32'hFE);
    bus_write(1'b1, 3'd2, 32'd5);
    for (int j = 0; j < 12; j++) begin
      exp_out  = (((j / 5) % 2) == 0) ? 8'hFF : 8'hFE;
      exp_stat = (32'(j % 5) << 8) | ((((j / 5) % 2) == 0) ? 32'h1 : 32'h0);
      check("blink5_out", 32'(out_port), 32'(exp_out));
      read_check("blink5_stat", 3'd3, exp_stat);
      @(negedge clk);
    end

    // Period 0 freezes blink on
    bus_write(1'b1, 3'd2, 32'd0);
    for (int j = 0; j < 3; j++) begin
      check("frozen_out", 32'(out_port), 32'hFF);
      read_check("frozen_stat", 3'd3, 32'h1);
      @(negedge clk);
    end

    // Async reset mid-blink
    bus_write(1'b1, 3'd2, 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_out", 32'(out_port), 32'hFE);
    read_check("pre_rst_stat", 3'd3, 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_out", 32'(out_port), 32'hA5);
    read_check("midrst_stat", 3'd3, 32'h1);
    read_check("midrst_bmask", 3'd1, 32'h0);
    read_check("midrst_bperiod", 3'd2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_out", 32'(out_port), 32'hA5);
    read_check("post_rst_stat", 3'd3, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
